// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ack;

    modport master (output imem_addr, output imem_req, input imem_data, input imem_ack);
    modport slave  (input imem_addr, input imem_req, output imem_data, output imem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word requests to imem, one-cycle delivery pulses to decode.
// Optional macro FETCH_TRACE_EN prints delivered and discarded fetches in simulation.
module fetch_unit #(
    parameter logic [31:0] START_PC   = 32'h80020000,
    parameter int unsigned PROG_WORDS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        pc,
    output logic [31:0]        insn,
    output logic               valid_insn,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [31:0] PROG_LIMIT = 32'(PROG_WORDS);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] addr_q;
    logic [31:0] count;
    logic        discard;
    logic [31:0] redir_addr;
    logic [31:0] req_addr;
    logic        issue;
    logic        ack_seen;

    assign redir_addr = redirect_pc & 32'hFFFF_FFFC;
    // A redirect arriving in the issuing cycle steers that very request.
    assign req_addr   = redirect ? redir_addr : fetch_pc;
    assign issue      = (state == REQ) && !stall;
    assign ack_seen   = (state == WAIT) && imem.imem_ack;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = issue ? req_addr : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= START_PC;
            addr_q     <= 32'h0;
            count      <= 32'h0;
            discard    <= 1'b0;
            pc         <= 32'h0;
            insn       <= 32'h0;
            valid_insn <= 1'b0;
            done       <= 1'b0;
        end else begin
            valid_insn <= 1'b0;
            case (state)
                IDLE: begin
                    if (redirect) fetch_pc <= redir_addr;
                    if (enable)   state    <= REQ;
                end
                REQ: begin
                    if (redirect) fetch_pc <= redir_addr;
                    if (!stall) begin
                        addr_q <= req_addr;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) fetch_pc <= redir_addr;
                    if (ack_seen) begin
                        discard <= 1'b0;
                        state   <= REQ;
                        // Data for a superseded address is dropped without counting.
                        if (!discard && !redirect) begin
                            pc         <= fetch_pc;
                            insn       <= imem.imem_data;
                            valid_insn <= 1'b1;
                            fetch_pc   <= fetch_pc + 32'd4;
                            count      <= count + 32'd1;
                            if (count + 32'd1 == PROG_LIMIT) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                DONE:    done  <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (valid_insn)
            $display("FETCH PC: %h Insn: %h", pc, insn);
        if (!reset && ack_seen && (discard || redirect))
            $display("FETCH discard PC: %h", imem.imem_addr);
    end
`else
    // Tracing compiled out; cycle behaviour is identical.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory responder acks requests, a monitor pops expected fetches.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        valid_insn;
    logic        done;

    fetch_unit_if bus ();

    fetch_unit #(.START_PC(32'h80020000), .PROG_WORDS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem       (bus),
        .pc         (pc),
        .insn       (insn),
        .valid_insn (valid_insn),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   deliv_cnt;
    int   ack_delay;
    int   pend;
    logic [31:0] paddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h80020000: return 32'h00000000;
            32'h80020004: return 32'h24020005;
            default:      return a ^ 32'h3C1D0F0F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.insn = mem_word(a);
        exp_q.push_back(e);
    endtask

    task automatic reset_dut();
        step();
        reset    = 1'b1;
        enable   = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (5) step();
        reset = 1'b0;
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int n;
        n = 0;
        while (deliv_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("deliv_cnt", 32'(deliv_cnt), 32'(target));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
        chk({tag, "_addr"},  bus.imem_addr,     32'd0);
        chk({tag, "_pc"},    pc,                32'd0);
        chk({tag, "_insn"},  insn,              32'd0);
        chk({tag, "_valid"}, 32'(valid_insn),   32'd0);
        chk({tag, "_done"},  32'(done),         32'd0);
    endtask

    initial begin
        int base;
        int reqs;
        exp_t e;

        vectors = 0; miscompares = 0; deliv_cnt = 0;
        ack_delay = 1; pend = 0; paddr = 32'h0;
        reset = 1'b1; enable = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_data = 32'h0;

        fork
            // Memory: ack ack_delay cycles after a request, data from mem_word.
            forever begin
                @(negedge clk);
                #3;
                if (bus.imem_req === 1'b1) begin
                    pend  = ack_delay;
                    paddr = bus.imem_addr;
                end
                @(posedge clk);
                #1;
                bus.imem_ack = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.imem_ack  = 1'b1;
                        bus.imem_data = mem_word(paddr);
                    end
                end
            end
            // Monitor: every delivery must match the head of the scoreboard.
            forever begin
                @(negedge clk);
                if (valid_insn === 1'b1) begin
                    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("deliv_pc", pc, e.pc);
                        chk("deliv_insn", insn, e.insn);
                    end
                    deliv_cnt++;
                end
            end
        join_none

        // Reset state
        reset_dut();
        chk_idle_outputs("reset");

        // Back-to-back fetch to PROG_WORDS, then done and silence
        ack_delay = 1;
        base = deliv_cnt;
        push(32'h80020000); push(32'h80020004); push(32'h80020008);
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("req_pattern", 32'(bus.imem_req), 32'(i % 2));
            if (i % 2 == 1)
                chk("req_addr", bus.imem_addr, 32'h80020000 + 32'(4 * ((i - 1) / 2)));
        end
        step();
        chk("done_after_last", 32'(done), 32'd1);
        chk("three_deliv", 32'(deliv_cnt - base), 32'd3);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.imem_req !== 1'b0) reqs++;
        end
        chk("req_after_done", 32'(reqs), 32'd0);
        chk("done_held", 32'(done), 32'd1);

        // Stall holds off the request at an unchanged address
        reset_dut();
        base = deliv_cnt;
        stall = 1'b1; enable = 1'b1;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.imem_req !== 1'b0) reqs++;
        end
        chk("req_under_stall", 32'(reqs), 32'd0);
        stall = 1'b0;
        #1;
        chk("req_after_stall", 32'(bus.imem_req), 32'd1);
        chk("addr_after_stall", bus.imem_addr, 32'h80020000);
        push(32'h80020000);
        wait_deliv(base + 1, 20);

        // Redirect while waiting: pending ack discarded, refetch at aligned target
        reset_dut();
        base = deliv_cnt;
        ack_delay = 3;
        enable = 1'b1;
        step();
        chk("rw_req", 32'(bus.imem_req), 32'd1);
        step();
        chk("rw_addr_hold", bus.imem_addr, 32'h80020000);
        redirect = 1'b1; redirect_pc = 32'h80020102;
        step();
        redirect = 1'b0;
        step();
        chk("rw_ack_seen", 32'(bus.imem_ack), 32'd1);
        step();
        chk("rw_no_deliv", 32'(deliv_cnt - base), 32'd0);
        chk("rw_new_req", 32'(bus.imem_req), 32'd1);
        chk("rw_new_addr", bus.imem_addr, 32'h80020100);
        push(32'h80020100);
        wait_deliv(base + 1, 20);

        // Redirect coinciding with ack: data dropped, count unchanged
        reset_dut();
        base = deliv_cnt;
        ack_delay = 1;
        push(32'h80020000);
        enable = 1'b1;
        step(); step(); step();
        chk("ra_second_addr", bus.imem_addr, 32'h80020004);
        step();
        chk("ra_ack_seen", 32'(bus.imem_ack), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h80030000;
        step();
        redirect = 1'b0;
        #1;
        chk("ra_deliv_one", 32'(deliv_cnt - base), 32'd1);
        chk("ra_req", 32'(bus.imem_req), 32'd1);
        chk("ra_addr", bus.imem_addr, 32'h80030000);
        push(32'h80030000); push(32'h80030004);
        wait_deliv(base + 3, 30);
        chk("ra_done", 32'(done), 32'd1);
        repeat (5) step();
        chk("ra_no_extra", 32'(deliv_cnt - base), 32'd3);

        // Reset in WAIT; the late ack must be ignored
        reset_dut();
        base = deliv_cnt;
        ack_delay = 1;
        push(32'h80020000);
        enable = 1'b1;
        wait_deliv(base + 1, 20);
        ack_delay = 3;
        step();
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        chk_idle_outputs("rst_wait");
        step();
        chk("late_ack_seen", 32'(bus.imem_ack), 32'd1);
        step();
        chk("late_ack_valid", 32'(valid_insn), 32'd0);
        chk("late_ack_deliv", 32'(deliv_cnt - base), 32'd1);
        ack_delay = 1;
        push(32'h80020000);
        enable = 1'b1;
        step();
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_addr", bus.imem_addr, 32'h80020000);
        wait_deliv(base + 2, 20);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
